// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// State encoding, stream framing sizes and the busy-state helper live here.
package instr_mem_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    // States in which a load is in flight and stream bytes are accepted.
    function automatic logic is_busy(input state_t s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader is the slave; the stream source / memory side is the master.
interface instr_mem_loader_if;
    import instr_mem_loader_pkg::*;

    logic              byte_valid_i;
    logic [BYTE_W-1:0] byte_data_i;
    logic              byte_ready_o;
    logic              imem_we_o;
    logic [WORD_W-1:0] imem_addr_o;
    logic [WORD_W-1:0] imem_wdata_o;

    modport master (
        output byte_valid_i, byte_data_i,
        input  byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o
    );

    modport slave (
        input  byte_valid_i, byte_data_i,
        output byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o
    );

endinterface

// File: rtl/instr_mem_loader_packer.sv
// Byte-to-word packer: assembles little-endian 32-bit words from accepted bytes.
// word_ready_c/word_c present the completed word in the cycle its last byte is accepted.
module instr_mem_loader_packer
    import instr_mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_ready_c,
    output logic [WORD_W-1:0] word_c
);

    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] sr;

    // New byte enters at the top, so the first byte ends up in bits [7:0].
    assign word_c       = {byte_data, sr[WORD_W-1:BYTE_W]};
    assign word_ready_c = byte_en && (cnt == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sr  <= '0;
        end else if (clr) begin
            cnt <= '0;
            sr  <= '0;
        end else if (byte_en) begin
            cnt <= cnt + CNT_W'(1);
            sr  <= word_c;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: parses a length/data/checksum byte stream, writes
// words to instruction memory and holds the CPU in reset until a verified load.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    instr_mem_loader_if.slave  bus,
    output logic               cpu_rst_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int unsigned LEN_W = LEN_BYTES * BYTE_W;
    localparam int unsigned IDX_W = ADDR_W + 1;

    state_t            state;
    state_t            nxt;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_full;
    logic [IDX_W-1:0]  idx;
    logic [BYTE_W-1:0] csum;
    logic              accept;
    logic              start_load;
    logic              last_word;
    logic              word_ready_c;
    logic [WORD_W-1:0] word_c;

    assign accept     = bus.byte_valid_i && bus.byte_ready_o;
    assign start_load = start_i && !is_busy(state);
    assign len_full   = {bus.byte_data_i, len[BYTE_W-1:0]};
    assign last_word  = (LEN_W'(idx) + LEN_W'(1)) == len;

    instr_mem_loader_packer u_packer (
        .clk          (clk_i),
        .rst_n        (rst_i),
        .clr          (start_load),
        .byte_en      (accept && (state == ST_DATA)),
        .byte_data    (bus.byte_data_i),
        .word_ready_c (word_ready_c),
        .word_c       (word_c)
    );

    // Next-state decode.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: if (start_i) nxt = ST_LEN0;
            ST_LEN0: if (accept) nxt = ST_LEN1;
            ST_LEN1: begin
                if (accept) begin
                    if (len_full == '0)                     nxt = ST_CSUM;
                    else if (len_full > LEN_W'(MAX_WORDS))  nxt = ST_ERR;
                    else                                    nxt = ST_DATA;
                end
            end
            ST_DATA: if (word_ready_c && last_word) nxt = ST_CSUM;
            ST_CSUM: begin
                if (accept) nxt = (bus.byte_data_i == csum) ? ST_DONE : ST_ERR;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // State, registered status outputs, counters and the memory write port.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state            <= ST_IDLE;
            bus.byte_ready_o <= 1'b0;
            bus.imem_we_o    <= 1'b0;
            bus.imem_addr_o  <= '0;
            bus.imem_wdata_o <= '0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            err_o            <= 1'b0;
            cpu_rst_o        <= 1'b0;
            len              <= '0;
            idx              <= '0;
            csum             <= '0;
        end else begin
            state            <= nxt;
            bus.byte_ready_o <= is_busy(nxt);
            busy_o           <= is_busy(nxt);
            done_o           <= (nxt == ST_DONE);
            err_o            <= (nxt == ST_ERR);
            cpu_rst_o        <= (nxt == ST_DONE);
            bus.imem_we_o    <= 1'b0;

            if (start_load) begin
                len  <= '0;
                idx  <= '0;
                csum <= '0;
            end

            if (accept) begin
                case (state)
                    ST_LEN0: len[BYTE_W-1:0] <= bus.byte_data_i;
                    ST_LEN1: len <= len_full;
                    ST_DATA: csum <= csum ^ bus.byte_data_i;
                    default: ;
                endcase
            end

            if (word_ready_c) begin
                bus.imem_we_o    <= 1'b1;
                bus.imem_addr_o  <= WORD_W'({idx, 2'b00});
                bus.imem_wdata_o <= word_c;
                idx              <= idx + IDX_W'(1);
            end
        end
    end

endmodule
